// File: rtl/y_md_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The decode stage reuses the op constants when it issues an RV32M operation.
package y_md_pkg;

  // Operation select
  localparam logic [1:0] MD_MUL   = 2'b00;  // low half of product
  localparam logic [1:0] MD_MULHU = 2'b01;  // high half of unsigned product
  localparam logic [1:0] MD_DIVU  = 2'b10;  // unsigned quotient
  localparam logic [1:0] MD_REMU  = 2'b11;  // unsigned remainder

  // Sequencer states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/y_md_addsub.sv
// N-bit adder/subtractor: sub=1 computes x - y as x + ~y + 1.
// cout is the carry out of the top bit; when subtracting, cout=1 means x >= y.
module y_md_addsub #(
  parameter int N = 33
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N-1:0] y_inv;

  // Conditional one's complement of the second operand
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_inv
      assign y_inv[gi] = y[gi] ^ sub;
    end
  endgenerate

  assign {cout, s} = {1'b0, x} + {1'b0, y_inv} + {{N{1'b0}}, sub};

endmodule

// File: rtl/y_mul_div.sv
// Iterative radix-2 multiply/divide unit (MUL, MULHU, DIVU, REMU).
// One shift-add (multiply) or restoring-subtract (divide) step per cycle,
// WIDTH steps per operation; a single adder/subtractor serves both paths.
module y_mul_div
  import y_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state_reg;
  logic [CW-1:0]    count_reg;
  logic [1:0]       op_reg;
  // acc_reg: product high half (multiply) or partial remainder (divide)
  logic [WIDTH:0]   acc_reg;
  // qr_reg: product low half / multiplier (multiply) or dividend/quotient (divide)
  logic [WIDTH-1:0] qr_reg;
  // mcand_reg: multiplicand (multiply) or divisor (divide)
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] z_reg;

  logic             is_div;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   as_x;
  logic [WIDTH:0]   as_y;
  logic [WIDTH:0]   as_sum;
  logic             as_cout;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] qr_next;
  logic [WIDTH-1:0] result_next;

  assign is_div  = op_reg[1];
  assign shifted = {acc_reg[WIDTH-1:0], qr_reg[WIDTH-1]};

  // Divide subtracts the divisor from the shifted remainder; multiply adds the
  // multiplicand to the high half only when the current multiplier bit is set.
  assign as_x = is_div ? shifted : acc_reg;
  assign as_y = (is_div || qr_reg[0]) ? {1'b0, mcand_reg} : '0;

  y_md_addsub #(.N(WIDTH + 1)) u_addsub (
    .x    (as_x),
    .y    (as_y),
    .sub  (is_div),
    .s    (as_sum),
    .cout (as_cout)
  );

  // One iteration: next accumulator/shift register values and the result they imply
  always_comb begin
    acc_next    = acc_reg;
    qr_next     = qr_reg;
    result_next = '0;
    if (is_div) begin
      // Carry out set means no borrow: trial remainder is non-negative
      acc_next = as_cout ? as_sum : shifted;
      qr_next  = {qr_reg[WIDTH-2:0], as_cout};
    end else begin
      // Shift {carry, hi, lo} right by one
      acc_next = {1'b0, as_sum[WIDTH:1]};
      qr_next  = {as_sum[0], qr_reg[WIDTH-1:1]};
    end
    case (op_reg)
      MD_MUL:   result_next = qr_next;
      MD_MULHU: result_next = acc_next[WIDTH-1:0];
      MD_DIVU:  result_next = qr_next;
      default:  result_next = acc_next[WIDTH-1:0];
    endcase
  end

  // Sequencer, operand capture, iteration registers and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      op_reg    <= MD_MUL;
      acc_reg   <= '0;
      qr_reg    <= '0;
      mcand_reg <= '0;
      z_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_reg <= S_RUN;
            op_reg    <= op;
            acc_reg   <= '0;
            count_reg <= CW'(WIDTH);
            // Multiply preloads the multiplier into the low half; divide shifts the dividend out
            qr_reg    <= op[1] ? a : b;
            mcand_reg <= op[1] ? b : a;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_reg   <= acc_next;
          qr_reg    <= qr_next;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= S_DONE;
            z_reg     <= result_next;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_reg == S_RUN);
  assign done = (state_reg == S_DONE);
  assign z    = z_reg;

endmodule

// File: tb/tb_y_mul_div.sv
// Self-checking bench for y_mul_div: directed RV32M cases plus randomized
// operations on a 32-bit and an 8-bit instance against an arithmetic model.
module tb_y_mul_div;
  import y_md_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, busy, done;
  logic [1:0]  op;
  logic [31:0] a, b, z;
  logic        start8, busy8, done8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, z8;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  y_mul_div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .z(z)
  );

  y_mul_div #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .z(z8)
  );

  // Reference: plain arithmetic on 64-bit values, RISC-V divide-by-zero rules
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int w);
    logic [63:0] m, xx, yy, p;
    m  = (64'd1 << w) - 64'd1;
    xx = {32'd0, x} & m;
    yy = {32'd0, y} & m;
    p  = xx * yy;
    case (o)
      MD_MUL:   return 32'(p & m);
      MD_MULHU: return 32'((p >> w) & m);
      MD_DIVU:  return (yy == 64'd0) ? 32'(m) : 32'(xx / yy);
      default:  return (yy == 64'd0) ? 32'(xx) : 32'(xx % yy);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op on the 32-bit unit; called and returns just after a negedge
  task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    int nb;
    nb = 0;
    lat = 0;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    while (!done && lat < 100) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
    res = z;
    check("busy_cycles", 32'(nb), 32'd32);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("latency", 32'(lat), 32'd32);
    $display("w32 op=%0d a=%h b=%h z=%h cycles=%0d", o, x, y, res, lat);
  endtask

  // Same for the 8-bit unit
  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      output logic [31:0] res, output int lat);
    lat = 0;
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    while (!done8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = {24'd0, z8};
    check("latency8", 32'(lat), 32'd8);
    $display("w8  op=%0d a=%h b=%h z=%h cycles=%0d", o, x, y, z8, lat);
  endtask

  initial begin
    logic [31:0] r, r2, x, y, expv;
    logic [1:0]  o;
    int lat, n, extra, t1, t2;

    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    start8 = 1'b0; op8 = 2'd0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_z", z, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic multiply, then result holds while idle
    run32(MD_MUL, 32'd7, 32'd6, r, lat);
    check("mul_7x6", r, 32'd42);
    repeat (5) @(negedge clk);
    check("mul_hold_z", z, 32'd42);
    check("mul_done_pulse", {31'd0, done}, 32'd0);

    run32(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
    check("mulhu_ff", r, 32'hFFFFFFFE);
    run32(MD_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
    check("mul_ff", r, 32'h00000001);
    run32(MD_DIVU, 32'd100, 32'd7, r, lat);
    check("divu_100_7", r, 32'd14);
    run32(MD_REMU, 32'd100, 32'd7, r, lat);
    check("remu_100_7", r, 32'd2);
    run32(MD_DIVU, 32'd5, 32'd0, r, lat);
    check("divu_by0", r, 32'hFFFFFFFF);
    run32(MD_REMU, 32'd5, 32'd0, r, lat);
    check("remu_by0", r, 32'd5);
    run32(MD_DIVU, 32'd3, 32'd10, r, lat);
    check("divu_a_lt_b", r, 32'd0);
    run32(MD_MULHU, 32'd0, 32'hDEADBEEF, r, lat);
    check("mulhu_a0", r, 32'd0);
    @(negedge clk);

    // start held high through RUN with different operands: one result from the first operands
    start = 1'b1; op = MD_MUL; a = 32'd5; b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    op = MD_DIVU; a = 32'd9; b = 32'd9;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("hold_start_z", z, 32'd25);
    check("hold_start_lat", 32'(n), 32'd32);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("hold_start_extra_done", 32'(extra), 32'd0);

    // Asynchronous reset in the middle of an operation
    start = 1'b1; op = MD_MUL; a = 32'd123; b = 32'd456;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_z", z, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run32(MD_MUL, 32'd3, 32'd3, r, lat);
    check("after_rst_mul", r, 32'd9);
    @(negedge clk);

    // Back-to-back accept from the DONE cycle
    run32(MD_DIVU, 32'd9, 32'd3, r, lat);
    t1 = cyc;
    check("b2b_divu", r, 32'd3);
    run32(MD_REMU, 32'd9, 32'd4, r2, lat);
    t2 = cyc;
    check("b2b_remu", r2, 32'd1);
    check("b2b_gap", 32'(t2 - t1), 32'd33);
    @(negedge clk);

    // Randomized 32-bit operations
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 4))
        0: y = 32'd0;
        1: y = $urandom_range(1, 255);
        2: x = $urandom_range(0, 1000);
        default: ;
      endcase
      expv = model(o, x, y, 32);
      run32(o, x, y, r, lat);
      check("rand32", r, expv);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    // 8-bit instance
    run8(MD_MULHU, 8'hFF, 8'hFF, r, lat);
    check("w8_mulhu_ff", r, 32'h000000FE);
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      x = {24'd0, 8'($urandom)};
      y = {24'd0, 8'($urandom)};
      if ($urandom_range(0, 5) == 0) y = 32'd0;
      expv = model(o, x, y, 8);
      run8(o, x[7:0], y[7:0], r, lat);
      check("rand8", r, expv);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
